// File: rtl/memory_control.sv
// Arbitrates icache reads and dcache reads/writes onto a single RAM port; completes each access
// with a one-cycle wait drop. Define MEMCTL_FAIR_ARB_EN for alternating arbitration on conflicts.
module memory_control #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StIacc = 2'd1;
  localparam logic [1:0] StDacc = 2'd2;

  localparam logic [1:0] RamAccess = 2'b10;
  localparam logic [1:0] RamError  = 2'b11;

  logic [1:0]       r_state;
  logic [1:0]       w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_error;
  logic             w_d_req;
  logic             w_pick_d;
  logic             w_ram_ok;
  logic             w_ram_fail;
  logic             w_done;
  logic             w_fail;

  assign w_d_req    = dREN | dWEN;
  assign w_ram_ok   = (ramstate == RamAccess);
  assign w_ram_fail = (ramstate == RamError) || (r_cnt == CNT_MAX);

  assign iload     = ramload;
  assign dload     = ramload;
  assign mem_error = r_mem_error;

`ifdef MEMCTL_FAIR_ARB_EN
  logic r_last_grant;  // 0 = instruction side, 1 = data side

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_last_grant <= 1'b0;
    end else if (w_done) begin
      r_last_grant <= (r_state == StDacc);
    end
  end

  assign w_pick_d = ~r_last_grant;
`else
  assign w_pick_d = 1'b1;
`endif

  always_comb begin
    w_state_d = r_state;
    iwait     = 1'b1;
    dwait     = 1'b1;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    w_done    = 1'b0;
    w_fail    = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_d_req && iREN) begin
          w_state_d = w_pick_d ? StDacc : StIacc;
        end else if (w_d_req) begin
          w_state_d = StDacc;
        end else if (iREN) begin
          w_state_d = StIacc;
        end
      end
      StDacc: begin
        if (!w_d_req) begin
          w_state_d = StIdle;  // abort: strobes already low, no wait pulse
        end else begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (w_ram_ok || w_ram_fail) begin
            dwait     = 1'b0;
            w_done    = 1'b1;
            w_fail    = ~w_ram_ok;
            w_state_d = StIdle;
          end
        end
      end
      StIacc: begin
        if (!iREN) begin
          w_state_d = StIdle;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (w_ram_ok || w_ram_fail) begin
            iwait     = 1'b0;
            w_done    = 1'b1;
            w_fail    = ~w_ram_ok;
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_mem_error <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_fail) begin
        r_mem_error <= 1'b1;
      end
    end
  end

endmodule
